// File: rtl/prime_pkg.sv
// Shared types and constants for the prime server.
// Imported by the FIFO and the server top.
package prime_pkg;

  typedef enum logic [2:0] {
    BOOT,
    ISSUE,
    SETTLE,
    WAIT,
    DONE
  } fstate_t;

  localparam int DEF_DEPTH_LOG = 2;

  function automatic int width_of(input int wlog);
    return 1 << wlog;
  endfunction

endpackage

// File: rtl/prime_fifo.sv
// Small synchronous FIFO for buffered primes.
// The owner guarantees no overflow and no underflow.
module prime_fifo
  import prime_pkg::*;
#(
  parameter int W         = 16,
  parameter int DEPTH_LOG = DEF_DEPTH_LOG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       wdata,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic [DEPTH_LOG:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(DEPTH);

  logic [W-1:0]         mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop && count == FULL));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (rst)
    !(pop && count == '0));

endmodule

// File: rtl/prime_server.sv
// Drives primogen to pre-fill a FIFO and shares
// buffered primes among consumers round-robin.
module prime_server
  import prime_pkg::*;
#(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = DEF_DEPTH_LOG,
  parameter int NREQ      = 2,
  localparam int W        = width_of(WIDTH_LOG)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pg_go,
  input  logic               pg_ready,
  input  logic               pg_error,
  input  logic [W-1:0]       pg_res,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    gnt,
  output logic [W-1:0]       data,
  output logic [DEPTH_LOG:0] level,
  output logic               exhausted
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int PW    = $clog2(NREQ);
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(DEPTH);

  fstate_t         fstate;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] elig;
  logic [W-1:0]    head;
  logic            push;
  logic            pop;

  // First eligible index at or after p, wrapping.
  function automatic logic [PW-1:0] rr_pick(
    input logic [NREQ-1:0] e,
    input logic [PW-1:0]   p
  );
    logic found;
    int   idx;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && e[PW'(idx)]) begin
        rr_pick = PW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  assign elig = req & ~gnt;
  assign pop  = (level != '0) && (elig != '0);
  assign win  = rr_pick(elig, rr_ptr);
  assign push = (fstate == WAIT) && pg_ready && !pg_error;

  prime_fifo #(
    .W         (W),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (pg_res),
    .pop   (pop),
    .head  (head),
    .count (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate <= BOOT;
      pg_go  <= 1'b0;
    end else begin
      pg_go <= 1'b0;
      unique case (fstate)
        BOOT: begin
          if (pg_ready && !pg_error) fstate <= ISSUE;
        end
        ISSUE: begin
          if (level < FULL) begin
            pg_go  <= 1'b1;
            fstate <= SETTLE;
          end
        end
        SETTLE: begin
          fstate <= WAIT;
        end
        WAIT: begin
          if (pg_ready) fstate <= pg_error ? DONE : ISSUE;
        end
        DONE: begin
          fstate <= DONE;
        end
        default: begin
          fstate <= BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      data      <= '0;
      rr_ptr    <= '0;
      exhausted <= 1'b0;
    end else begin
      exhausted <= (fstate == DONE) && (level == '0);
      if (pop) begin
        gnt    <= NREQ'(1) << win;
        data   <= head;
        rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      end else begin
        gnt <= '0;
      end
    end
  end

endmodule

// File: doc/prime_server.md
# prime_server

Prime-serving scheduler that owns one `primogen` instance and shares its output among `NREQ` consumers. It drives `primogen`'s `go`/`ready` handshake to pre-compute primes into a small FIFO. It then hands buffered primes to requesting consumers under round-robin arbitration, so no two consumers receive the same prime and none is starved. It sits between `primogen` and board-level logic such as progress displays and checkers, replacing ad-hoc `go` sequencing in top levels.

## Interface

Parameters:
- `WIDTH_LOG`, default 4: prime width is W = 2^WIDTH_LOG bits. Must match the `primogen` instance.
- `DEPTH_LOG`, default 2: FIFO depth is 2^DEPTH_LOG entries.
- `NREQ`, default 2: number of consumers, from 2 to 8.

Ports:
- `clk`, input, 1 bit: single clock.
- `rst`, input, 1 bit: synchronous, active-high reset. It is shared with the `primogen` instance.
- `pg_go`, output, 1 bit: one-cycle start pulse to `primogen`.
- `pg_ready`, input, 1 bit: `primogen` ready.
- `pg_error`, input, 1 bit: `primogen` overflow (no further prime fits in W bits).
- `pg_res`, input, W bits: `primogen` result.
- `req`, input, NREQ bits: per-consumer request, level-sensitive.
- `gnt`, output, NREQ bits: one-hot grant pulse.
- `data`, output, W bits: prime delivered. Valid only in a cycle where `gnt` is non-zero.
- `level`, output, DEPTH_LOG+1 bits: FIFO occupancy.
- `exhausted`, output, 1 bit: set when `pg_error` has been seen and the FIFO is empty.

## Operation

Fill FSM, with state held in `fstate`:
- **BOOT** (reset state). Waits for `pg_ready && !pg_error`. The `pg_res` present at boot is discarded. Then goes to ISSUE.
- **ISSUE**. If `level < 2^DEPTH_LOG`, assert `pg_go` for one cycle and go to SETTLE. Otherwise stay in ISSUE.
- **SETTLE**. One cycle so `primogen` can register `go`. Any stale `pg_ready` is ignored. Then go to WAIT.
- **WAIT**. On `pg_ready`:
  - If `pg_error`, go to DONE.
  - Otherwise push `pg_res` and go to ISSUE.
- **DONE**. Sticky, left only by `rst`. `pg_go` stays low.

Generation rules:
- Only one generation is ever outstanding.
- The space check in ISSUE guarantees the push in WAIT never overflows the FIFO.

Arbiter:
- A consumer is eligible when `req[i] && !gnt[i]`. A consumer that holds `req` therefore gets at most one grant every other cycle.
- When `level > 0` and any consumer is eligible, pick the first eligible index at or after `rr_ptr`, wrapping around.
- Register `gnt` as one-hot, pop the FIFO head into `data`, and set `rr_ptr` to the winner + 1 modulo NREQ.
- With no eligible consumer, `gnt` = 0, `data` holds its last value and `rr_ptr` holds.

Boundary conditions:
- **Push and pop in the same cycle:** `level` is unchanged and the FIFO order is preserved.
- **Empty FIFO:** no grant, and no bypass; a value pushed in cycle t is grantable at the earliest at the clock edge ending cycle t+1.
- **Full FIFO:** the FSM parks in ISSUE and `pg_go` stays low.
- **`pg_error` seen:** entries already in the FIFO are still served. `exhausted` rises in the cycle after the final pop.
- **`rst` mid-operation:** the FSM returns to BOOT, the FIFO and `rr_ptr` are cleared, and any in-flight `primogen` result is lost. `primogen` is reset by the same signal.

## Timing

- **Reset values:** `pg_go`=0, `gnt`=0, `data`=0, `level`=0, `exhausted`=0, `fstate`=BOOT, `rr_ptr`=0.
- **Registered outputs:** all outputs are registered; no combinational path runs from input to output.
- **Grant latency:** if `req[i]` is high in cycle t, `i` is eligible and `level>0`, then `gnt[i]` and `data` are asserted in cycle t+1.
- **`pg_go` spacing:** `pg_go` pulses are at least 3 cycles apart (ISSUE → SETTLE → WAIT → ISSUE).
- **Push timing:**
  - The push occurs in the cycle `pg_ready` is sampled in WAIT.
  - `level` reflects the push on the following cycle.

## Structure

- **Package `prime_pkg`:**
  - FSM state enum (BOOT, ISSUE, SETTLE, WAIT, DONE).
  - Width helper: W from WIDTH_LOG.
  - Default depth constant.
- **Sub-module `prime_fifo`:**
  - Synchronous FIFO with simultaneous push and pop.
  - Count output; no overflow/underflow protection internally, since `prime_server` guarantees legality.
  - Asserts on illegal push/pop in simulation only.
- **Round-robin pick:** an in-module function; it does not warrant its own module.

## Test plan

The bench uses a behavioral `primogen` model. It takes 5 cycles per result, returns 2, 3, 5, 7, 11, then raises `pg_error` on the 6th `go`. Parameters are DEPTH_LOG=2, NREQ=2.
- **Fill with no requests:** no requests after reset → `level` reaches 4 with contents 2, 3, 5, 7, and `pg_go` stays low thereafter.
- **Alternation:** both `req` held after the fill → `gnt` alternates 01, 10, 01, 10 in consecutive cycles with `data` = 2, 3, 5, 7. The FSM then resumes and 11 is delivered.
- **Single holder:** only `req[1]` held continuously → `gnt[1]` pulses every other cycle, never back-to-back.
- **Exhaustion:** drain past 11 → FSM in DONE, no further `pg_go`, and `exhausted`=1 one cycle after the final pop. Requests then get no grant.
- **Push/pop collision:** a push coinciding with a grant at `level`=1 → `level` stays 1 and the values arrive in order.
- **Reset mid-operation:** `rst` asserted during WAIT with `level`=2 → the next cycle shows `level`=0, `gnt`=0 and BOOT. After reset, the sequence restarts at 2.
